// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: initiator FSM states, default bus widths,
// a packed command record and a byte-lane merge helper for responders.
package wb_pkg;

    localparam int WB_ADR_W   = 32;
    localparam int WB_DAT_W   = 32;
    localparam int WB_SEL_W   = WB_DAT_W / 8;
    localparam int WB_TIMEOUT = 255;
    localparam int WB_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

    // Apply a write to a stored word honouring the byte enables.
    function automatic logic [WB_DAT_W-1:0] wb_merge(
        input logic [WB_DAT_W-1:0] old_word,
        input logic [WB_DAT_W-1:0] new_word,
        input logic [WB_SEL_W-1:0] sel
    );
        logic [WB_DAT_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (sel[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// when LIMIT cycles have elapsed. LIMIT = 0 means it never expires.
module wb_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    generate
        if (LIMIT == 0) begin : g_off
            logic w_unused;
            assign w_unused  = ^{clk, i_rst_n, i_clr, i_en};
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
            localparam logic [W-1:0] LAST = W'(LIMIT - 1);

            logic [W-1:0] r_count;

            // Saturates so a stalled enable can never wrap back below LAST.
            always_ff @(posedge clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_count <= '0;
                end else if (i_clr) begin
                    r_count <= '0;
                end else if (i_en && (r_count != {W{1'b1}})) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_expired = (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: turns a valid/ready command
// stream into bus cycles and returns read data or a timeout error.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int ADR_W          = WB_ADR_W,
    parameter int DAT_W          = WB_DAT_W,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT,
    parameter int CNT_W          = WB_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic               rsp_err,

    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic [DAT_W-1:0]   wbm_dat_i,

    output logic               busy,
    output logic [CNT_W-1:0]   txn_count
);

    localparam int SEL_W = DAT_W / 8;

    wb_state_t          r_state;
    wb_state_t          w_state_next;
    logic               r_cyc;
    logic               w_cyc_next;
    logic               r_we;
    logic               w_we_next;
    logic [ADR_W-1:0]   r_adr;
    logic [ADR_W-1:0]   w_adr_next;
    logic [DAT_W-1:0]   r_dat;
    logic [DAT_W-1:0]   w_dat_next;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_next;
    logic               r_rsp_valid;
    logic               w_rsp_valid_next;
    logic [DAT_W-1:0]   r_rsp_dat;
    logic [DAT_W-1:0]   w_rsp_dat_next;
    logic               r_rsp_err;
    logic               w_rsp_err_next;
    logic [CNT_W-1:0]   r_txn_count;
    logic [CNT_W-1:0]   w_txn_count_next;

    logic               w_tmo_clr;
    logic               w_tmo_en;
    logic               w_tmo_expired;

    wb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .i_rst_n   (reset_n),
        .i_clr     (w_tmo_clr),
        .i_en      (w_tmo_en),
        .o_expired (w_tmo_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_txn_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cyc       <= w_cyc_next;
            r_we        <= w_we_next;
            r_adr       <= w_adr_next;
            r_dat       <= w_dat_next;
            r_sel       <= w_sel_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_dat   <= w_rsp_dat_next;
            r_rsp_err   <= w_rsp_err_next;
            r_txn_count <= w_txn_count_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cyc_next       = r_cyc;
        w_we_next        = r_we;
        w_adr_next       = r_adr;
        w_dat_next       = r_dat;
        w_sel_next       = r_sel;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_dat_next   = r_rsp_dat;
        w_rsp_err_next   = r_rsp_err;
        w_txn_count_next = r_txn_count;
        w_tmo_clr        = 1'b0;
        w_tmo_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_we_next    = cmd_we;
                    w_adr_next   = cmd_adr;
                    w_dat_next   = cmd_dat;
                    w_sel_next   = cmd_sel;
                    w_cyc_next   = 1'b1;
                    w_tmo_clr    = 1'b1;
                    w_state_next = ST_BUS;
                end
            end

            ST_BUS: begin
                w_tmo_en = 1'b1;
                // ACK is checked first so a late ACK on the final cycle still succeeds.
                if (wbm_ack_i) begin
                    w_cyc_next       = 1'b0;
                    w_rsp_dat_next   = r_we ? '0 : wbm_dat_i;
                    w_rsp_err_next   = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_txn_count_next = r_txn_count + 1'b1;
                    w_state_next     = ST_RESP;
                end else if (w_tmo_expired) begin
                    w_cyc_next       = 1'b0;
                    w_rsp_dat_next   = '0;
                    w_rsp_err_next   = 1'b1;
                    w_rsp_valid_next = 1'b1;
                    w_txn_count_next = r_txn_count + 1'b1;
                    w_state_next     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_state_next     = ST_IDLE;
                end
            end

            default: begin
                w_cyc_next       = 1'b0;
                w_rsp_valid_next = 1'b0;
                w_state_next     = ST_IDLE;
            end
        endcase
    end

    // Gated by reset_n so cmd_ready reads 0 while reset is held.
    assign cmd_ready = reset_n && (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: directed and random commands against a
// memory-backed responder with programmable wait states.
`timescale 1ns/1ps
module tb_wb_initiator;
    import wb_pkg::*;

    localparam int TMO   = 8;
    localparam int CNT_W = 4;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        busy;
    logic [CNT_W-1:0] txn_count;

    always #5 clk = ~clk;

    wb_initiator #(
        .ADR_W(32), .DAT_W(32), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .busy(busy), .txn_count(txn_count)
    );

    typedef struct {
        wb_cmd_t         cmd;
        logic [31:0]     exp_dat;
        logic            exp_err;
        logic [CNT_W-1:0] exp_cnt;
        int              exp_stb;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cur_waits = 0;
    int          rdy_mode = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] ref_mem[16];
    logic [CNT_W-1:0] exp_cnt;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 ^ (i * 32'h0101_0137);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Responder: ACKs after cur_waits STB cycles, memory reloads on reset.
    int          resp_cnt;
    logic [31:0] resp_mem[16];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       resp_cnt <= 0;
        else if (wbm_stb_o && !wbm_ack_i)   resp_cnt <= resp_cnt + 1;
        else                                resp_cnt <= 0;
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) resp_mem[i] <= init_word(i);
        end else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o) begin
            resp_mem[wbm_adr_o[5:2]] <= wb_merge(resp_mem[wbm_adr_o[5:2]], wbm_dat_o, wbm_sel_o);
        end
    end

    assign wbm_ack_i = (wbm_cyc_o && wbm_stb_o && (resp_cnt >= cur_waits)) || stray_ack;
    assign wbm_dat_i = resp_mem[wbm_adr_o[5:2]];

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks bus fields during STB and pops the scoreboard on each response handshake.
    int   stb_len = 0;
    logic prev_valid = 1'b0;
    logic prev_stb = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stb_len    = 0;
                prev_valid = 1'b0;
                prev_stb   = 1'b0;
            end else begin
                if (wbm_stb_o) begin
                    stb_len++;
                    check("q_depth_on_stb", sb_q.size(), 1);
                    check("cyc_with_stb", wbm_cyc_o, 1);
                    if (sb_q.size() > 0) begin
                        check("bus_adr", wbm_adr_o, sb_q[0].cmd.adr);
                        check("bus_we", wbm_we_o, sb_q[0].cmd.we);
                        check("bus_sel", wbm_sel_o, sb_q[0].cmd.sel);
                        check("bus_dat", wbm_dat_o, sb_q[0].cmd.dat);
                    end
                end
                if (rsp_valid) begin
                    check("cmd_ready_in_resp", cmd_ready, 0);
                    check("cyc_in_resp", wbm_cyc_o, 0);
                    if (!prev_valid) check("stb_before_rsp", prev_stb, 1);
                    if (rsp_ready) begin
                        check("q_depth_on_rsp", sb_q.size(), 1);
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            check("rsp_dat", rsp_dat, e.exp_dat);
                            check("rsp_err", rsp_err, e.exp_err);
                            check("txn_count", txn_count, e.exp_cnt);
                            check("stb_cycles", stb_len, e.exp_stb);
                        end
                        stb_len = 0;
                    end
                end
                prev_valid = rsp_valid;
                prev_stb   = wbm_stb_o;
            end
        end
    end

    // Drive a command, push its expected outcome the cycle it is accepted.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int waits);
        exp_t e;
        int   k;
        int   idx;
        idx = int'(adr[5:2]);
        @(negedge clk);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            bound_fail("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        cur_waits   = waits;
        e.cmd.we    = we;
        e.cmd.adr   = adr;
        e.cmd.dat   = dat;
        e.cmd.sel   = sel;
        e.exp_err   = (waits >= TMO);
        e.exp_stb   = (waits >= TMO) ? TMO : waits + 1;
        if (e.exp_err) begin
            e.exp_dat = 32'h0;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
            e.exp_dat = 32'h0;
        end else begin
            e.exp_dat = ref_mem[idx];
        end
        exp_cnt   = exp_cnt + 1'b1;
        e.exp_cnt = exp_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb_q.size() != 0 || !cmd_ready) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) bound_fail("wait_idle");
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) bound_fail("wait_rsp");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r_adr_rand;
        logic [3:0]  idx;
        int          wait_tab[6];
        wait_tab = '{0, 1, 2, 3, 7, NEVER};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        exp_cnt = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_dat", rsp_dat, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_we", wbm_we_o, 0);
        check("rst_sel", wbm_sel_o, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_txn_count", txn_count, 0);

        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0);
        wait_idle();
        check("txn_count_first", txn_count, 1);

        issue(1'b1, 32'h3000_0008, 32'h1234_5678, 4'hF, 0);
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3);
        wait_idle();

        issue(1'b0, 32'h3000_000C, 32'h0, 4'hF, NEVER);
        wait_idle();

        rdy_mode = 2;
        issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1);
        wait_rsp();
        fork
            issue(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'b0101, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid_held", rsp_valid, 1);
                    if (sb_q.size() > 0) check("bp_dat_held", rsp_dat, sb_q[0].exp_dat);
                end
                rdy_mode = 0;
            end
        join
        wait_idle();

        @(negedge clk) stray_ack = 1'b1;
        @(negedge clk);
        check("stray_idle_busy", busy, 0);
        check("stray_idle_valid", rsp_valid, 0);
        check("stray_idle_cyc", wbm_cyc_o, 0);
        check("stray_idle_count", txn_count, exp_cnt);
        stray_ack = 1'b0;

        rdy_mode = 2;
        issue(1'b0, 32'h3000_0014, 32'h0, 4'hF, 0);
        wait_rsp();
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("stray_resp_valid", rsp_valid, 1);
        check("stray_resp_busy", busy, 1);
        check("stray_resp_cyc", wbm_cyc_o, 0);
        check("stray_resp_count", txn_count, exp_cnt);
        stray_ack = 1'b0;
        rdy_mode = 0;
        wait_idle();

        issue(1'b0, 32'h3000_0018, 32'h0, 4'hF, NEVER);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_cyc", wbm_cyc_o, 0);
        check("midrst_stb", wbm_stb_o, 0);
        check("midrst_valid", rsp_valid, 0);
        check("midrst_count", txn_count, 0);
        check("midrst_busy", busy, 0);
        sb_q.delete();
        exp_cnt   = '0;
        cur_waits = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 1);
        issue(1'b0, 32'h3000_001C, 32'h0, 4'hF, 2);
        wait_idle();

        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            r_adr_rand = $urandom;
            idx        = 4'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), {r_adr_rand[31:6], idx, 2'b00}, $urandom,
                  4'($urandom_range(1, 15)), wait_tab[$urandom_range(0, 5)]);
        end
        wait_idle();
        rdy_mode = 0;
        check("final_q_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
Single-outstanding Wishbone classic (B3) initiator. It converts a valid/ready command stream into bus cycles toward a Wishbone responder, such as the A5/1 register interface. It returns read data or a timeout error on a valid/ready response stream. It sits between a local controller (LA-driven sequencer or test harness) and the user-area Wishbone responders.

Parameters:
ADR_W, 32, address width
DAT_W, 32, data width (byte lanes = DAT_W/8)
TIMEOUT_CYCLES, 255, max cycles STB held without ACK before abort; 0 disables timeout
CNT_W, 16, width of completed-transaction counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&ready
cmd_we  input  1  1=write, 0=read
cmd_adr  input  ADR_W  byte address
cmd_dat  input  DAT_W  write data
cmd_sel  input  DAT_W/8  byte enables
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when valid&ready
rsp_dat  output  DAT_W  read data; 0 for writes and errors
rsp_err  output  1  1=timeout abort
wbm_cyc_o  output  1  Wishbone CYC
wbm_stb_o  output  1  Wishbone STB
wbm_we_o  output  1  Wishbone WE
wbm_sel_o  output  DAT_W/8  Wishbone SEL
wbm_adr_o  output  ADR_W  Wishbone ADR
wbm_dat_o  output  DAT_W  Wishbone write data
wbm_ack_i  input  1  Wishbone ACK
wbm_dat_i  input  DAT_W  Wishbone read data
busy  output  1  state != IDLE
txn_count  output  CNT_W  completed transactions (ack or error), wraps

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous assert, active low, synchronous deassert expected from the SoC.
- On reset, all outputs are 0: cmd_ready, rsp_*, wbm_*, busy, txn_count. State is IDLE.
- All outputs are registered, except cmd_ready = (state==IDLE) and busy.
- FSM states: IDLE, BUS, RESP.
- IDLE: when cmd_valid&cmd_ready, latch we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear the timeout counter, go to BUS. cyc/stb go high the cycle after acceptance.
- BUS:
  - If wbm_ack_i is sampled high: cyc=stb=0 next cycle. rsp_dat <= we ? 0 : wbm_dat_i. rsp_err <= 0. rsp_valid <= 1. txn_count++. Go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and the counter == TIMEOUT_CYCLES-1: cyc=stb=0, rsp_err <= 1, rsp_dat <= 0, rsp_valid <= 1, txn_count++, go to RESP.
  - Else the counter increments, saturating.
  - ACK wins over a timeout in the same cycle.
- wbm_adr/dat/sel/we are held stable for the whole BUS state. After the cycle ends they keep their last value; cyc=0 makes them don't-care.
- RESP: rsp_valid and rsp_dat/rsp_err are held stable until rsp_ready. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE. cmd_ready rises the following cycle. No command is accepted in RESP.
- Minimum latency: accept at edge N, STB high N+1..M, ACK sampled at edge M, rsp_valid high after M. With a zero-wait-state responder, M=N+1 and command-to-response is 2 cycles. Minimum issue interval is 3 cycles with rsp_ready tied high.
- wbm_ack_i is ignored in IDLE and RESP; a stray ACK has no effect.
- txn_count wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-BUS drops cyc/stb immediately (asynchronous). The in-flight command is lost with no response.
- ERR/RTY/bursts are not supported. CTI/BTE are not driven.

Decomposition:
- Shared package wb_pkg: FSM state enum (IDLE/BUS/RESP), default widths, and a packed wb_cmd struct {we, adr, dat, sel}, reusable by responders and the bench.
- The timeout counter is a natural sub-module, wb_timeout: parameterised limit, clear/enable inputs, expired output, zero limit = never expires.
- The FSM and bus registers stay in wb_initiator.

Test Plan:
- Write, zero-wait responder: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF -> wbm_* show these values for exactly 1 STB cycle; rsp_valid 2 cycles after accept with rsp_err=0, rsp_dat=0; txn_count=1.
- Read, 3-wait responder returning 0x1234_5678 -> STB held 4 cycles with stable adr; rsp_dat=0x1234_5678, rsp_err=0; cyc low the cycle after ACK.
- Timeout, TIMEOUT_CYCLES=8, responder never acks -> STB high exactly 8 cycles, then cyc=0, rsp_err=1, rsp_dat=0, txn_count increments.
- Response backpressure: rsp_ready held low 5 cycles with a new cmd_valid pending -> rsp_valid/rsp_dat stable, cmd_ready=0 throughout; next command accepted the cycle after the rsp handshake.
- Reset mid-BUS: drop reset_n while STB is high -> cyc/stb/rsp_valid/txn_count 0 before the next clock edge; after release, cmd_ready=1 and a new read completes normally.
- Stray ACK in IDLE and RESP, plus txn_count wrap with CNT_W=4 after 16 transactions -> no state change from the stray ACKs; txn_count reads 0 after the 16th transaction.
